// File: rtl/pkt_capture.sv
// pkt_capture: Avalon-ST ingress that pushes packet words into the shared FIFO and hands each packet to wr_ctrl; PKT_CAPTURE_TIMESTAMP_EN adds a leading cycle-timestamp word.
// Latency: an accepted beat is written to the FIFO on the next cycle; wr_ctrl rises one cycle after the last word write.
// Backpressure: st_ready drops on almost_full or a stray sop while capturing, and stays low from handoff until wr_ctrl_rdy.
module pkt_capture #(
    parameter logic [31:0] BUF_BASE      = 32'h0000_8000,
    parameter logic [31:0] BUF_SIZE      = 32'h0001_0000,
    parameter int          MAX_PKT_WORDS = 384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] st_data,
    input  logic        st_valid,
    input  logic        st_sop,
    input  logic        st_eop,
    input  logic [1:0]  st_empty,
    output logic        st_ready,
    output logic [31:0] fifo_in,
    output logic        wrreq,
    input  logic        almost_full,
    output logic        wr_ctrl,
    output logic [31:0] pkt_begin,
    output logic [31:0] pkt_end,
    output logic [31:0] control,
    output logic [31:0] write_address,
    input  logic        wr_ctrl_rdy,
    output logic [31:0] pkt_count,
    output logic [15:0] drop_count
);

    typedef enum logic [2:0] {IDLE, CAPTURE, HANDOFF, WAIT_DONE, TS_SLOT} state_t;

    localparam logic [15:0] MAX_WORDS = 16'(MAX_PKT_WORDS);
    localparam logic [31:0] MAX_BYTES = 32'(MAX_PKT_WORDS) << 2;
    localparam logic [31:0] BUF_END   = BUF_BASE + BUF_SIZE;
`ifdef PKT_CAPTURE_TIMESTAMP_EN
    localparam logic [15:0] TS_WORDS  = 16'd1;
    localparam logic        TS_FLAG   = 1'b1;
`else
    localparam logic [15:0] TS_WORDS  = 16'd0;
    localparam logic        TS_FLAG   = 1'b0;
`endif

    state_t      state, state_nxt;
    logic [15:0] wcnt;
    logic [15:0] tot;
    logic [15:0] tot_inc;
    logic [15:0] bytelen;
    logic        trunc;
    logic        frame;
    logic        accept;
    logic        drop_evt;
    logic [31:0] next_addr;
`ifdef PKT_CAPTURE_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] hold_dat;
    logic        hold_eop;
`endif

    // Byte length counts every beat of the packet, saturating at 16 bits.
    function automatic logic [15:0] byte_len(input logic [15:0] beats, input logic [1:0] empty);
        logic [17:0] b;
        b = {beats, 2'b00} - {16'd0, empty};
        return (b > 18'h0FFFF) ? 16'hFFFF : b[15:0];
    endfunction

    assign accept    = st_valid && st_ready;
    assign drop_evt  = accept && ((state == IDLE && !st_sop) ||
                                  (state == CAPTURE && wcnt >= MAX_WORDS));
    assign tot_inc   = (tot == 16'hFFFF) ? tot : tot + 16'd1;
    assign next_addr = write_address + pkt_end;
    assign pkt_begin = 32'd0;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && st_sop) begin
`ifdef PKT_CAPTURE_TIMESTAMP_EN
                    state_nxt = TS_SLOT;
`else
                    state_nxt = st_eop ? HANDOFF : CAPTURE;
`endif
                end
            end
`ifdef PKT_CAPTURE_TIMESTAMP_EN
            TS_SLOT:   state_nxt = hold_eop ? HANDOFF : CAPTURE;
`endif
            CAPTURE: begin
                if (st_valid && st_sop)    state_nxt = HANDOFF;
                else if (accept && st_eop) state_nxt = HANDOFF;
            end
            HANDOFF:   state_nxt = WAIT_DONE;
            WAIT_DONE: if (wr_ctrl_rdy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        st_ready = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    st_ready = 1'b1;
                CAPTURE: st_ready = !almost_full && !st_sop;
                default: st_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_in       <= '0;
            wrreq         <= 1'b0;
            wr_ctrl       <= 1'b0;
            pkt_end       <= '0;
            control       <= '0;
            write_address <= BUF_BASE;
            pkt_count     <= '0;
            drop_count    <= '0;
            wcnt          <= '0;
            tot           <= '0;
            bytelen       <= '0;
            trunc         <= 1'b0;
            frame         <= 1'b0;
`ifdef PKT_CAPTURE_TIMESTAMP_EN
            ts_cnt        <= '0;
            hold_dat      <= '0;
            hold_eop      <= 1'b0;
`endif
        end else begin
            wrreq <= 1'b0;
`ifdef PKT_CAPTURE_TIMESTAMP_EN
            ts_cnt <= ts_cnt + 32'd1;
`endif
            if (drop_evt && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            case (state)
                IDLE: begin
                    if (accept && st_sop) begin
                        wcnt    <= 16'd1;
                        tot     <= 16'd1;
                        trunc   <= 1'b0;
                        frame   <= 1'b0;
                        wrreq   <= 1'b1;
                        bytelen <= byte_len(16'd1, st_empty);
`ifdef PKT_CAPTURE_TIMESTAMP_EN
                        fifo_in  <= ts_cnt;
                        hold_dat <= st_data;
                        hold_eop <= st_eop;
`else
                        fifo_in  <= st_data;
`endif
                    end
                end
`ifdef PKT_CAPTURE_TIMESTAMP_EN
                TS_SLOT: begin
                    wrreq   <= 1'b1;
                    fifo_in <= hold_dat;
                end
`endif
                CAPTURE: begin
                    // A new sop closes the current packet with what has been stored.
                    if (st_valid && st_sop) begin
                        frame   <= 1'b1;
                        bytelen <= byte_len(tot, 2'd0);
                    end else if (accept) begin
                        tot <= tot_inc;
                        if (wcnt < MAX_WORDS) begin
                            wrreq   <= 1'b1;
                            fifo_in <= st_data;
                            wcnt    <= wcnt + 16'd1;
                        end else begin
                            trunc <= 1'b1;
                        end
                        if (st_eop) bytelen <= byte_len(tot_inc, st_empty);
                    end
                end
                HANDOFF: begin
                    wr_ctrl <= 1'b1;
                    pkt_end <= {14'd0, wcnt + TS_WORDS, 2'b00};
                    control <= {13'd0, TS_FLAG, frame, trunc, bytelen};
                end
                WAIT_DONE: begin
                    if (wr_ctrl_rdy) begin
                        wr_ctrl       <= 1'b0;
                        pkt_count     <= pkt_count + 32'd1;
                        // Never let a worst-case job straddle the ring end.
                        write_address <= (next_addr + MAX_BYTES > BUF_END) ? BUF_BASE : next_addr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_capture.sv
// Bench for pkt_capture: directed and random packets checked against a packet-level reference model.
module tb_pkt_capture;

    localparam int          MAXW = 384;
    localparam logic [31:0] BASE = 32'h0000_8000;
    localparam logic [31:0] SIZE = 32'h0000_1000;

    logic        clk;
    logic        reset;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_sop;
    logic        st_eop;
    logic [1:0]  st_empty;
    logic        st_ready;
    logic [31:0] fifo_in;
    logic        wrreq;
    logic        almost_full;
    logic        wr_ctrl;
    logic [31:0] pkt_begin;
    logic [31:0] pkt_end;
    logic [31:0] control;
    logic [31:0] write_address;
    logic        wr_ctrl_rdy;
    logic [31:0] pkt_count;
    logic [15:0] drop_count;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] pkt_dat[0:511];
    logic [31:0] m_addr;
    logic [31:0] e_end;
    logic [31:0] e_ctrl;
    int          m_pkts;
    int          m_drops;

    pkt_capture #(
        .BUF_BASE(BASE),
        .BUF_SIZE(SIZE),
        .MAX_PKT_WORDS(MAXW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .st_data(st_data),
        .st_valid(st_valid),
        .st_sop(st_sop),
        .st_eop(st_eop),
        .st_empty(st_empty),
        .st_ready(st_ready),
        .fifo_in(fifo_in),
        .wrreq(wrreq),
        .almost_full(almost_full),
        .wr_ctrl(wr_ctrl),
        .pkt_begin(pkt_begin),
        .pkt_end(pkt_end),
        .control(control),
        .write_address(write_address),
        .wr_ctrl_rdy(wr_ctrl_rdy),
        .pkt_count(pkt_count),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (!reset && wrreq) got_q.push_back(fifo_in);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic prep_pkt(input int n);
        for (int i = 0; i < n; i++) pkt_dat[i] = $urandom;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic s, input logic e,
                             input logic [1:0] emp, input bit af_rand);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            st_data     = d;
            st_valid    = 1'b1;
            st_sop      = s;
            st_eop      = e;
            st_empty    = emp;
            almost_full = af_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
            #1;
            done = (st_ready === 1'b1);
            n++;
            if (!done && n > 200) begin
                chk("beat_accept_timeout", {31'd0, st_ready}, 32'd1);
                done = 1;
            end
            @(posedge clk);
        end
    endtask

    task automatic send_beats(input int first, input int last, input logic [1:0] emp,
                              input bit af_rand, input bit eop_last);
        for (int i = first; i < last; i++) begin
            send_beat(pkt_dat[i], i == 0, eop_last && (i == last - 1),
                      (eop_last && (i == last - 1)) ? emp : 2'd0, af_rand);
        end
    endtask

    task automatic release_bus;
        @(negedge clk);
        st_valid    = 1'b0;
        st_sop      = 1'b0;
        st_eop      = 1'b0;
        st_empty    = 2'd0;
        almost_full = 1'b0;
    endtask

    // Expected job for a packet of n beats taken from pkt_dat.
    task automatic model_pkt(input int n, input logic [1:0] emp, input bit frame);
        int stored;
        int bl;
        stored = (n > MAXW) ? MAXW : n;
        for (int i = 0; i < stored; i++) exp_q.push_back(pkt_dat[i]);
        e_end = 32'(stored * 4);
        bl    = frame ? n * 4 : n * 4 - int'(emp);
        if (bl > 65535) bl = 65535;
        e_ctrl = 32'(bl) | ((n > MAXW) ? 32'h0001_0000 : 32'd0) | (frame ? 32'h0002_0000 : 32'd0);
        if (n > MAXW) m_drops = m_drops + (n - MAXW);
        if (m_drops > 65535) m_drops = 65535;
    endtask

    task automatic wait_job(input string tag);
        int n;
        n = 0;
        while (wr_ctrl !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wr_ctrl"}, {31'd0, wr_ctrl}, 32'd1);
    endtask

    task automatic do_job(input string tag, input int dly);
        bit          held_bad;
        logic [31:0] nxt;
        int          nw;
        wait_job(tag);
        chk({tag, "_wrreq_at_job"}, {31'd0, wrreq}, 32'd0);
        chk({tag, "_pkt_begin"}, pkt_begin, 32'd0);
        chk({tag, "_pkt_end"}, pkt_end, e_end);
        chk({tag, "_control"}, control, e_ctrl);
        chk({tag, "_write_address"}, write_address, m_addr);
        chk({tag, "_fifo_words"}, 32'(got_q.size()), 32'(exp_q.size()));
        nw = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nw; i++) chk({tag, "_fifo_data"}, got_q[i], exp_q[i]);
        held_bad = 0;
        repeat (dly) begin
            @(negedge clk);
            if (wr_ctrl !== 1'b1 || pkt_end !== e_end || control !== e_ctrl || write_address !== m_addr)
                held_bad = 1;
        end
        chk({tag, "_job_held"}, {31'd0, held_bad}, 32'd0);
        wr_ctrl_rdy = 1'b1;
        @(negedge clk);
        wr_ctrl_rdy = 1'b0;
        m_pkts++;
        nxt = m_addr + e_end;
        m_addr = (nxt + 32'(MAXW * 4) > BASE + SIZE) ? BASE : nxt;
        chk({tag, "_wr_ctrl_drop"}, {31'd0, wr_ctrl}, 32'd0);
        chk({tag, "_pkt_count"}, pkt_count, 32'(m_pkts));
        chk({tag, "_next_address"}, write_address, m_addr);
        chk({tag, "_drop_count"}, {16'd0, drop_count}, 32'(m_drops));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int          n0;
        int          n;
        logic [1:0]  emp;

        reset       = 1'b1;
        st_data     = '0;
        st_valid    = 1'b0;
        st_sop      = 1'b0;
        st_eop      = 1'b0;
        st_empty    = 2'd0;
        almost_full = 1'b0;
        wr_ctrl_rdy = 1'b0;
        m_addr      = BASE;
        m_pkts      = 0;
        m_drops     = 0;

        repeat (3) @(negedge clk);
        chk("rst_st_ready", {31'd0, st_ready}, 32'd0);
        chk("rst_wrreq", {31'd0, wrreq}, 32'd0);
        chk("rst_wr_ctrl", {31'd0, wr_ctrl}, 32'd0);
        chk("rst_fifo_in", fifo_in, 32'd0);
        chk("rst_pkt_end", pkt_end, 32'd0);
        chk("rst_control", control, 32'd0);
        chk("rst_write_address", write_address, BASE);
        chk("rst_pkt_count", pkt_count, 32'd0);
        chk("rst_drop_count", {16'd0, drop_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_st_ready", {31'd0, st_ready}, 32'd1);

        // 8-beat packet 0x10..0x17
        for (int i = 0; i < 8; i++) pkt_dat[i] = 32'h10 + 32'(i);
        send_beats(0, 8, 2'd0, 0, 1);
        model_pkt(8, 2'd0, 0);
        release_bus;
        do_job("p8", 5);
        chk("p8_addr_const", write_address, 32'h0000_8020);
        chk("p8_count_const", pkt_count, 32'd1);

        // 3 beats, empty=3 on eop
        prep_pkt(3);
        send_beats(0, 3, 2'd3, 0, 1);
        model_pkt(3, 2'd3, 0);
        release_bus;
        do_job("p3", 2);

        // stray beats in IDLE
        for (int i = 0; i < 3; i++) send_beat($urandom, 1'b0, 1'b0, 2'd0, 0);
        release_bus;
        m_drops = m_drops + 3;
        @(negedge clk);
        chk("stray_drop_count", {16'd0, drop_count}, 32'(m_drops));
        chk("stray_no_job", {31'd0, wr_ctrl}, 32'd0);

        // oversize packet
        prep_pkt(400);
        send_beats(0, 400, 2'd0, 0, 1);
        model_pkt(400, 2'd0, 0);
        release_bus;
        do_job("trunc", 1);

        // second sop after 4 beats
        prep_pkt(4);
        send_beats(0, 4, 2'd0, 0, 0);
        model_pkt(4, 2'd0, 1);
        prep_pkt(6);
        @(negedge clk);
        st_data  = pkt_dat[0];
        st_valid = 1'b1;
        st_sop   = 1'b1;
        st_eop   = 1'b0;
        st_empty = 2'd0;
        #1;
        chk("frame_sop_refused", {31'd0, st_ready}, 32'd0);
        do_job("frame", 3);
        send_beats(1, 6, 2'd2, 0, 1);
        model_pkt(6, 2'd2, 0);
        release_bus;
        do_job("frame_next", 1);

        // almost_full stall mid-packet
        prep_pkt(10);
        send_beats(0, 3, 2'd0, 0, 0);
        @(negedge clk);
        st_data     = pkt_dat[3];
        st_valid    = 1'b1;
        st_sop      = 1'b0;
        st_eop      = 1'b0;
        almost_full = 1'b1;
        #1;
        chk("af_st_ready", {31'd0, st_ready}, 32'd0);
        n0 = got_q.size();
        repeat (4) @(negedge clk);
        #1;
        chk("af_no_wrreq", 32'(got_q.size()), 32'(n0));
        send_beats(3, 10, 2'd1, 0, 1);
        model_pkt(10, 2'd1, 0);
        release_bus;
        do_job("af", 0);

        // random packets with random almost_full and rdy delays
        for (int k = 0; k < 8; k++) begin
            n   = $urandom_range(1, 40);
            emp = 2'($urandom_range(0, 3));
            prep_pkt(n);
            send_beats(0, n, emp, 1, 1);
            model_pkt(n, emp, 0);
            release_bus;
            do_job("rnd", $urandom_range(0, 6));
        end

        // reset while a job is pending
        prep_pkt(5);
        send_beats(0, 5, 2'd0, 0, 1);
        release_bus;
        wait_job("rstjob");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstjob_wr_ctrl", {31'd0, wr_ctrl}, 32'd0);
        chk("rstjob_write_address", write_address, BASE);
        chk("rstjob_pkt_count", pkt_count, 32'd0);
        chk("rstjob_drop_count", {16'd0, drop_count}, 32'd0);
        reset = 1'b0;
        m_addr  = BASE;
        m_pkts  = 0;
        m_drops = 0;
        got_q.delete();
        exp_q.delete();
        @(negedge clk);

        // back-to-back full-size jobs wrap the ring
        for (int k = 0; k < 3; k++) begin
            prep_pkt(MAXW);
            send_beats(0, MAXW, 2'd0, 0, 1);
            model_pkt(MAXW, 2'd0, 0);
            release_bus;
            do_job("wrap", 1);
            if (k == 1) chk("wrap_third_addr", write_address, 32'h0000_8000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pkt_capture.md
Name: pkt_capture

Overview:
- Ingress stage directly upstream of wr_ctrl.
- Accepts an Avalon-ST packet stream (32-bit beats, sop/eop/empty) and pushes payload words into the shared SCFIFO.
- On each completed packet, asserts a wr_ctrl job with pkt_begin/pkt_end/control/write_address. Holds the job until wr_ctrl_rdy reports completion.
- Manages write_address as a ring over a fixed DDR capture region.

Parameters:
- BUF_BASE, 32'h0000_8000, byte base address of the capture ring.
- BUF_SIZE, 32'h0001_0000, ring size in bytes; must be a multiple of 4 and at least MAX_PKT_WORDS*4.
- MAX_PKT_WORDS, 384, words stored per packet; further beats are dropped and the packet is flagged truncated.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- st_data  in  32  stream beat
- st_valid  in  1  beat valid
- st_sop  in  1  first beat of packet
- st_eop  in  1  last beat of packet
- st_empty  in  2  unused bytes in the eop beat
- st_ready  out  1  beat accepted when st_valid && st_ready
- fifo_in  out  32  FIFO write data
- wrreq  out  1  FIFO write strobe
- almost_full  in  1  FIFO almost-full flag
- wr_ctrl  out  1  job request to wr_ctrl, level
- pkt_begin  out  32  job start offset; always 0
- pkt_end  out  32  job length in bytes, multiple of 4
- control  out  32  [15:0] exact byte length, [16] truncated, [17] framing error, [31:18] 0
- write_address  out  32  job destination byte address
- wr_ctrl_rdy  in  1  single-cycle pulse: job written to memory
- pkt_count  out  32  packets handed off; wraps
- drop_count  out  16  beats discarded outside a packet or past MAX_PKT_WORDS; saturates at FFFF

Behaviour:
- Reset values:
  - st_ready=0, wrreq=0, wr_ctrl=0, fifo_in=0
  - pkt_begin=0, pkt_end=0, control=0
  - write_address=BUF_BASE
  - counters=0
  - state=IDLE
- Reset mid-job drops wr_ctrl immediately. FIFO flushing is the top level's concern.
- All outputs are registered except st_ready, which is combinational from state, almost_full and st_sop.
- IDLE:
  - st_ready=1.
  - Accepted beat with sop: write word, wcnt=1, go to CAPTURE. If it also has eop, go straight to HANDOFF.
  - Accepted beat without sop: discard, drop_count+1.
- CAPTURE:
  - st_ready = !almost_full && !st_sop.
  - Accepted beat with wcnt<MAX_PKT_WORDS: wrreq=1 next cycle, fifo_in=st_data, wcnt+1.
  - Accepted beat with wcnt=MAX_PKT_WORDS: not written, truncated flag set, drop_count+1.
  - eop accepted: bytelen = wcnt_total*4 - st_empty, counting every beat of the packet but capped at 16 bits. Go to HANDOFF.
  - st_valid && st_sop seen in CAPTURE: beat refused, framing-error flag set, go to HANDOFF with the words stored so far. The sop beat is accepted later from IDLE.
- HANDOFF:
  - st_ready=0.
  - Next cycle: wr_ctrl=1, pkt_end = stored words*4, control latched. Go to WAIT_DONE.
  - The FIFO write of the last word always precedes the wr_ctrl rise by at least 1 cycle.
- WAIT_DONE:
  - st_ready=0; wr_ctrl held at 1 with stable job fields.
  - On wr_ctrl_rdy: wr_ctrl=0, pkt_count+1.
  - next = write_address + pkt_end. If next + MAX_PKT_WORDS*4 > BUF_BASE+BUF_SIZE, write_address=BUF_BASE, else write_address=next.
  - Return to IDLE.
  - wr_ctrl_rdy in any other state is ignored.
- Jobs never split across the ring end; address arithmetic is 32-bit.
- Throughput: 1 beat/cycle in CAPTURE while almost_full=0.

Optional Feature:
- Macro PKT_CAPTURE_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter, reset to 0.
  - Its value at sop acceptance is written as the first FIFO word, one cycle before the sop data word. st_ready is low for that one inserted cycle.
  - pkt_end includes the 4 timestamp bytes; MAX_PKT_WORDS counts payload only.
  - control[18]=1.
- Undefined: no counter, no extra word, control[18]=0.

Test Plan:
- 8-beat packet 10..17, empty=0, rdy pulse 5 cycles after wr_ctrl -> FIFO gets 10..17; wr_ctrl=1 with pkt_end=32, control=0x20, write_address=0x8000; after rdy: pkt_count=1, write_address=0x8020.
- 3-beat packet, eop empty=3 -> pkt_end=12, control[15:0]=9.
- 400-beat packet with MAX_PKT_WORDS=384 -> 384 FIFO writes, pkt_end=1536, control[16]=1, drop_count=16.
- Second sop while in CAPTURE after 4 beats -> job pkt_end=16 with control[17]=1; second packet then captured intact.
- Address wrap: BUF_SIZE=0x1000 with back-to-back 384-word jobs -> third job write_address=0x8000. Stray non-sop beats in IDLE -> drop_count increments. almost_full=1 -> st_ready=0 and no wrreq.
- Reset asserted in WAIT_DONE -> next cycle wr_ctrl=0, write_address=0x8000, pkt_count=0.
